// File: rtl/delay_timer_arbiter.sv
// Shared millisecond delay engine. One requester at a time is granted in
// round-robin order. The engine counts the requested number of milliseconds
// and then returns a one-cycle done pulse to that requester.
module delay_timer_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int CYCLES_PER_MS = 25000,
    parameter int DUR_WIDTH     = 11,
    parameter int ID_WIDTH      = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*DUR_WIDTH-1:0] duration,
    output logic [NUM_REQ-1:0]           grant,
    output logic [NUM_REQ-1:0]           done,
    output logic                         busy,
    output logic [ID_WIDTH-1:0]          active_id
);

    localparam int MS_W = (CYCLES_PER_MS > 1) ? $clog2(CYCLES_PER_MS) : 1;
    localparam logic [MS_W-1:0] MS_RELOAD = MS_W'(CYCLES_PER_MS - 1);

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        DONE
    } state_t;

    state_t               state, state_next;
    logic [NUM_REQ-1:0]   grant_next;
    logic [ID_WIDTH-1:0]  active_id_next;
    logic [ID_WIDTH-1:0]  rr_ptr, rr_ptr_next;
    logic [MS_W-1:0]      ms_cnt, ms_cnt_next;
    logic [DUR_WIDTH-1:0] remaining, remaining_next;

    logic                 found_hi, found_lo;
    logic [ID_WIDTH-1:0]  win_hi, win_lo, winner;
    logic [DUR_WIDTH-1:0] win_dur;
    logic                 granted_req;
    logic [ID_WIDTH-1:0]  ptr_after_active;

    // Round-robin search: the lowest requester at or above rr_ptr wins. If there
    // is none, the lowest requester overall wins, which gives the wrap-around.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        win_hi   = '0;
        win_lo   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (req[i] && !found_hi && (i >= 32'(rr_ptr))) begin
                found_hi = 1'b1;
                win_hi   = ID_WIDTH'(i);
            end
            if (req[i] && !found_lo) begin
                found_lo = 1'b1;
                win_lo   = ID_WIDTH'(i);
            end
        end
        winner = found_hi ? win_hi : win_lo;
    end

    // Select the duration slice of the winning requester.
    always_comb begin
        win_dur = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (ID_WIDTH'(i) == winner) begin
                win_dur = duration[i*DUR_WIDTH +: DUR_WIDTH];
            end
        end
    end

    assign granted_req      = |(req & grant);
    assign ptr_after_active = (active_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : active_id + 1'b1;

    // Next-state logic for the FSM and datapath. Every signal is given a default first.
    always_comb begin
        state_next     = state;
        grant_next     = grant;
        active_id_next = active_id;
        rr_ptr_next    = rr_ptr;
        ms_cnt_next    = ms_cnt;
        remaining_next = remaining;
        case (state)
            IDLE: begin
                if (found_lo) begin
                    state_next     = COUNT;
                    grant_next     = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
                    active_id_next = winner;
                    remaining_next = win_dur;
                    ms_cnt_next    = MS_RELOAD;
                end
            end
            COUNT: begin
                if (!granted_req) begin
                    // Abort: the owner withdrew its request, so no done is issued.
                    state_next     = IDLE;
                    grant_next     = '0;
                    active_id_next = '0;
                    rr_ptr_next    = ptr_after_active;
                    ms_cnt_next    = '0;
                    remaining_next = '0;
                end else if (remaining == '0) begin
                    state_next = DONE;
                end else if (ms_cnt == '0) begin
                    remaining_next = remaining - 1'b1;
                    ms_cnt_next    = MS_RELOAD;
                end else begin
                    ms_cnt_next = ms_cnt - 1'b1;
                end
            end
            DONE: begin
                state_next     = IDLE;
                grant_next     = '0;
                active_id_next = '0;
                rr_ptr_next    = ptr_after_active;
                ms_cnt_next    = '0;
                remaining_next = '0;
            end
            default: begin
                state_next     = IDLE;
                grant_next     = '0;
                active_id_next = '0;
            end
        endcase
    end

    // State and datapath registers. Reset discards any delay still in progress.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            grant     <= '0;
            active_id <= '0;
            rr_ptr    <= '0;
            ms_cnt    <= '0;
            remaining <= '0;
        end else begin
            state     <= state_next;
            grant     <= grant_next;
            active_id <= active_id_next;
            rr_ptr    <= rr_ptr_next;
            ms_cnt    <= ms_cnt_next;
            remaining <= remaining_next;
        end
    end

    assign done = (state == DONE) ? grant : '0;
    assign busy = |grant;

endmodule

// File: tb/tb_delay_timer_arbiter.sv
// Directed testbench for delay_timer_arbiter. It uses CYCLES_PER_MS=10 for the
// main tests and CYCLES_PER_MS=2 for the maximum-duration test.
module tb_delay_timer_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [43:0] duration;
    logic [3:0]  grant, done;
    logic        busy;
    logic [1:0]  active_id;

    logic [3:0]  req_b;
    logic [43:0] duration_b;
    logic [3:0]  grant_b, done_b;
    logic        busy_b;
    logic [1:0]  active_id_b;

    int tests = 0;
    int fails = 0;

    delay_timer_arbiter #(.NUM_REQ(4), .CYCLES_PER_MS(10), .DUR_WIDTH(11), .ID_WIDTH(2)) dut (
        .clock(clock), .reset(reset), .req(req), .duration(duration),
        .grant(grant), .done(done), .busy(busy), .active_id(active_id)
    );

    delay_timer_arbiter #(.NUM_REQ(4), .CYCLES_PER_MS(2), .DUR_WIDTH(11), .ID_WIDTH(2)) dut_b (
        .clock(clock), .reset(reset), .req(req_b), .duration(duration_b),
        .grant(grant_b), .done(done_b), .busy(busy_b), .active_id(active_id_b)
    );

    // Free-running clock
    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic set_dur(input int idx, input logic [10:0] d);
        duration[idx*11 +: 11] = d;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        req   = '0;
        tick;
        reset = 1'b0;
    endtask

    task automatic wait_grant(input int bound, output int n);
        n = 0;
        while (grant == 4'b0000 && n < bound) begin
            tick;
            n++;
        end
        if (grant == 4'b0000) n = -1;
    endtask

    task automatic wait_done(input int bound, output int n);
        n = 0;
        while (done == 4'b0000 && n < bound) begin
            tick;
            n++;
        end
        if (done == 4'b0000) n = -1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        req   = 4'b1111;
        duration = '0;
        tick;
        tick;
        tests++; if (grant !== 4'b0000) begin fails++; $display("FAIL reset_grant: got %b expected 0000", grant); end
        tests++; if (done !== 4'b0000) begin fails++; $display("FAIL reset_done: got %b expected 0000", done); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests++; if (active_id !== 2'd0) begin fails++; $display("FAIL reset_active_id: got %0d expected 0", active_id); end
        reset = 1'b0;
        req   = '0;
        tick;
    endtask

    task automatic test_single_grant;
        int n;
        do_reset;
        set_dur(0, 11'd3);
        req = 4'b0001;
        tick;
        tests++; if (grant !== 4'b0001) begin fails++; $display("FAIL single_grant: got %b expected 0001", grant); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy: got %b expected 1", busy); end
        tests++; if (active_id !== 2'd0) begin fails++; $display("FAIL single_active_id: got %0d expected 0", active_id); end
        wait_done(100, n);
        tests++; if (n !== 31) begin fails++; $display("FAIL single_latency: got %0d expected 31", n); end
        tests++; if (done !== 4'b0001) begin fails++; $display("FAIL single_done: got %b expected 0001", done); end
        tests++; if (grant !== 4'b0001) begin fails++; $display("FAIL single_grant_in_done: got %b expected 0001", grant); end
        req = 4'b0000;
        tick;
        tests++; if (done !== 4'b0000) begin fails++; $display("FAIL single_done_width: got %b expected 0000", done); end
        tests++; if (grant !== 4'b0000 || busy !== 1'b0) begin fails++; $display("FAIL single_release: got grant=%b busy=%b expected 0000/0", grant, busy); end
    endtask

    task automatic test_round_robin;
        int n;
        logic [3:0] exp_g;
        do_reset;
        for (int i = 0; i < 4; i++) set_dur(i, 11'd1);
        req = 4'b1111;
        tick;
        for (int k = 0; k < 4; k++) begin
            exp_g = 4'b0001 << k;
            if (k > 0) begin
                wait_grant(10, n);
                tests++; if (n !== 1) begin fails++; $display("FAIL rr_gap_%0d: got %0d expected 1", k, n); end
            end
            tests++; if (grant !== exp_g) begin fails++; $display("FAIL rr_grant_%0d: got %b expected %b", k, grant, exp_g); end
            tests++; if (active_id !== 2'(k)) begin fails++; $display("FAIL rr_active_id_%0d: got %0d expected %0d", k, active_id, k); end
            wait_done(50, n);
            tests++; if (n !== 11 || done !== exp_g) begin fails++; $display("FAIL rr_done_%0d: got n=%0d done=%b expected 11/%b", k, n, done, exp_g); end
            req[k] = 1'b0;
            tick;
        end
        req = 4'b0101;
        wait_grant(10, n);
        tests++; if (grant !== 4'b0001 || n !== 1) begin fails++; $display("FAIL rr_wrap_first: got %b n=%0d expected 0001 n=1", grant, n); end
        wait_done(50, n);
        req[0] = 1'b0;
        tick;
        wait_grant(10, n);
        tests++; if (grant !== 4'b0100 || n !== 1) begin fails++; $display("FAIL rr_wrap_second: got %b n=%0d expected 0100 n=1", grant, n); end
        wait_done(50, n);
        req = 4'b0000;
        tick;
    endtask

    task automatic test_fairness;
        int n;
        do_reset;
        for (int i = 0; i < 4; i++) set_dur(i, 11'd1);
        req = 4'b0010;
        tick;
        tests++; if (grant !== 4'b0010) begin fails++; $display("FAIL fair_first: got %b expected 0010", grant); end
        wait_done(50, n);
        req = 4'b0101;
        tick;
        wait_grant(10, n);
        tests++; if (grant !== 4'b0100 || n !== 1) begin fails++; $display("FAIL fair_second: got %b n=%0d expected 0100 n=1", grant, n); end
        wait_done(50, n);
        req = 4'b0001;
        tick;
        wait_grant(10, n);
        tests++; if (grant !== 4'b0001) begin fails++; $display("FAIL fair_third: got %b expected 0001", grant); end
        wait_done(50, n);
        req = 4'b0000;
        tick;
    endtask

    task automatic test_zero_duration;
        do_reset;
        set_dur(2, 11'd0);
        req = 4'b0100;
        tick;
        tests++; if (grant !== 4'b0100 || done !== 4'b0000) begin fails++; $display("FAIL zero_grant: got grant=%b done=%b expected 0100/0000", grant, done); end
        tick;
        tests++; if (done !== 4'b0100 || grant !== 4'b0100) begin fails++; $display("FAIL zero_done: got done=%b grant=%b expected 0100/0100", done, grant); end
        req = 4'b0000;
        tick;
        tests++; if (done !== 4'b0000 || grant !== 4'b0000) begin fails++; $display("FAIL zero_release: got done=%b grant=%b expected 0000/0000", done, grant); end
    endtask

    task automatic test_abort;
        logic saw_done;
        do_reset;
        set_dur(1, 11'd5);
        set_dur(3, 11'd0);
        req = 4'b1010;
        tick;
        tests++; if (grant !== 4'b0010) begin fails++; $display("FAIL abort_grant: got %b expected 0010", grant); end
        saw_done = 1'b0;
        repeat (7) begin
            tick;
            if (done !== 4'b0000) saw_done = 1'b1;
        end
        req[1] = 1'b0;
        tick;
        if (done !== 4'b0000) saw_done = 1'b1;
        tests++; if (saw_done !== 1'b0) begin fails++; $display("FAIL abort_no_done: got done seen=%b expected 0", saw_done); end
        tests++; if (grant !== 4'b0000 || busy !== 1'b0) begin fails++; $display("FAIL abort_release: got grant=%b busy=%b expected 0000/0", grant, busy); end
        tick;
        tests++; if (grant !== 4'b1000 || active_id !== 2'd3) begin fails++; $display("FAIL abort_next_grant: got %b id=%0d expected 1000 id=3", grant, active_id); end
        tick;
        tests++; if (done !== 4'b1000) begin fails++; $display("FAIL abort_next_done: got %b expected 1000", done); end
        req = 4'b0000;
        tick;
    endtask

    task automatic test_reset_mid_count;
        do_reset;
        set_dur(3, 11'd100);
        set_dur(0, 11'd0);
        req = 4'b1000;
        tick;
        tests++; if (grant !== 4'b1000) begin fails++; $display("FAIL rmid_grant: got %b expected 1000", grant); end
        repeat (50) tick;
        reset = 1'b1;
        req   = 4'b1001;
        tick;
        tests++; if (grant !== 4'b0000 || done !== 4'b0000 || busy !== 1'b0 || active_id !== 2'd0) begin
            fails++; $display("FAIL rmid_cleared: got grant=%b done=%b busy=%b id=%0d expected all 0", grant, done, busy, active_id);
        end
        reset = 1'b0;
        tick;
        tests++; if (grant !== 4'b0001) begin fails++; $display("FAIL rmid_ptr_reset: got %b expected 0001", grant); end
        tick;
        tests++; if (done !== 4'b0001) begin fails++; $display("FAIL rmid_done0: got %b expected 0001", done); end
        req = 4'b0000;
        tick;
    endtask

    task automatic test_max_duration;
        int n;
        duration_b[10:0] = 11'd2047;
        req_b = 4'b0001;
        tick;
        tests++; if (grant_b !== 4'b0001 || busy_b !== 1'b1) begin fails++; $display("FAIL max_grant: got %b busy=%b expected 0001/1", grant_b, busy_b); end
        n = 0;
        while (done_b == 4'b0000 && n < 5000) begin
            tick;
            n++;
        end
        tests++; if (n !== 4095) begin fails++; $display("FAIL max_latency: got %0d expected 4095", n); end
        tests++; if (active_id_b !== 2'd0) begin fails++; $display("FAIL max_active_id: got %0d expected 0", active_id_b); end
        req_b = 4'b0000;
        tick;
        tests++; if (grant_b !== 4'b0000 || done_b !== 4'b0000) begin fails++; $display("FAIL max_release: got grant=%b done=%b expected 0000/0000", grant_b, done_b); end
    endtask

    // Test sequence
    initial begin
        reset      = 1'b1;
        req        = '0;
        duration   = '0;
        req_b      = '0;
        duration_b = '0;
        test_reset;
        test_single_grant;
        test_round_robin;
        test_fairness;
        test_zero_duration;
        test_abort;
        test_reset_mid_count;
        test_max_duration;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/delay_timer_arbiter.md
Name: delay_timer_arbiter

Overview:
- Shares one millisecond delay engine among NUM_REQ requesters, such as face-motor step sequencers and settle/hold timers.
- Each requester asks for a delay of N ms. The block grants one requester at a time in round-robin order, counts the delay, and returns a one-cycle done pulse to that requester.
- Sits between the motor/move sequencing FSMs and the clock domain. It replaces per-requester private timers.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- CYCLES_PER_MS, 25000, clock cycles per millisecond.
- DUR_WIDTH, 11, width of each requested duration in ms.
- ID_WIDTH, 2, width of active_id; must satisfy 2**ID_WIDTH >= NUM_REQ.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high
- req  input  NUM_REQ  per-requester request level; held high until done or abort
- duration  input  NUM_REQ*DUR_WIDTH  packed; slice i = duration[i*DUR_WIDTH +: DUR_WIDTH], delay in ms for requester i
- grant  output  NUM_REQ  one-hot (or zero); requester owning the engine
- done  output  NUM_REQ  one-cycle pulse to the owning requester when its delay expires
- busy  output  1  high while any grant is active
- active_id  output  ID_WIDTH  index of granted requester; 0 when idle

Behaviour:
- Reset: grant=0, done=0, busy=0, active_id=0, rr_ptr=0, ms counter=0, ms remaining=0, state=IDLE. Reset has priority over all events, including mid-count: the count is discarded and no done is issued.
- States: IDLE, COUNT, DONE.
- IDLE, clock edge with any req high:
  - Select the winner by searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - Latch its duration slice into remaining.
  - Set ms counter = CYCLES_PER_MS-1.
  - Set grant[winner]=1, active_id=winner, busy=1.
  - Go to COUNT.
  - grant is visible the cycle after the edge that sampled req.
- IDLE, no req: hold; all outputs 0.
- COUNT, remaining==0 at an edge: go to DONE. done[winner]=1 for exactly one cycle; grant stays high during the done cycle.
- COUNT, remaining>0:
  - If ms counter==0: remaining--, ms counter reloads CYCLES_PER_MS-1.
  - Else: ms counter--.
- Latency: done rises exactly D*CYCLES_PER_MS+1 cycles after grant rises, where D = latched duration. D=0 gives done on the cycle immediately after grant rises.
- Duration is sampled only at grant. Changes to the duration input afterward are ignored for the current delay.
- DONE, next edge: grant=0, done=0, busy=0, active_id=0, rr_ptr = winner+1 mod NUM_REQ, go to IDLE.
  - IDLE needs at least one cycle before the next grant, so back-to-back grants are 1 idle cycle apart.
  - Requester drops req on the edge ending done. A req still high in IDLE is treated as a new request.
- Abort: granted req low at any COUNT edge:
  - Cancel the count; no done is issued.
  - grant/busy/active_id clear after that edge.
  - rr_ptr = winner+1; go to IDLE.
- Non-granted req changes during COUNT/DONE are ignored until IDLE.
- A req rising in the same cycle as another's done is arbitrated in the following IDLE cycle.
- Counters: ms counter width = clog2(CYCLES_PER_MS); remaining width = DUR_WIDTH. Maximum duration 2**DUR_WIDTH-1 ms, with no overflow or wrap.
- Invariants: grant is one-hot or zero; done is asserted only where grant is asserted; busy == |grant.

Test Plan (CYCLES_PER_MS=10, NUM_REQ=4):
- Single grant: req[0]=1, duration0=3 → grant[0] rises 1 cycle after req is sampled; done[0] high exactly 1 cycle, 31 cycles after grant rises; grant/busy low the following cycle; active_id=0 throughout.
- Round-robin: req[3:0]=4'b1111, all durations=1, each requester drops req after its done → grant order 0,1,2,3. Then raise req[0] and req[2] together → grant 0 (rr_ptr wrapped to 0), then 2.
- Fairness: after requester 1 is served, req[0] and req[2] high together → grant[2] first (rr_ptr=2), then grant[0].
- Zero duration: req[2]=1, duration2=0 → done[2] on the cycle immediately after grant[2] rises, 1 cycle wide.
- Abort: req[1]=1, duration1=5; drop req[1] 7 cycles after grant → grant/busy clear next cycle, no done pulse; a pending req[3] is granted 1 idle cycle later.
- Reset mid-count: reset pulsed during a duration=100 count for requester 3 → all outputs 0 next cycle, no done; then req[3] and req[0] high together → grant[0] first (rr_ptr reset to 0). Also check maximum duration 2047 at CYCLES_PER_MS=2 → done after 4095 cycles.
